// File: rtl/ulpb_lc_tx_sequencer.sv
// Layer-controller transmit sequencer: buffers words in a small FIFO and plays them out over the
// node TX_REQ/TX_ACK handshake as one message. Define ULPB_TX_SEQ_TIMEOUT_EN to add a watchdog.
module ulpb_lc_tx_sequencer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       CLKIN,
    input  logic                       RESETn,
    input  logic                       WR_EN,
    input  logic [DATA_W-1:0]          WR_DATA,
    output logic                       WR_FULL,
    output logic [$clog2(DEPTH):0]     FIFO_LEVEL,
    input  logic [ADDR_W-1:0]          MSG_ADDR,
    input  logic                       MSG_PRIORITY,
    input  logic                       MSG_GO,
    output logic                       MSG_BUSY,
    output logic                       MSG_DONE,
    output logic [1:0]                 MSG_STATUS,
    output logic [ADDR_W-1:0]          TX_ADDR,
    output logic [DATA_W-1:0]          TX_DATA,
    output logic                       TX_REQ,
    output logic                       TX_PEND,
    output logic                       PRIORITY,
    input  logic                       TX_ACK,
    input  logic                       TX_SUCC,
    input  logic                       TX_FAIL,
    output logic                       TX_RESP_ACK
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAckLow,
        StAckFlush,
        StResp,
        StRack
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [LVL_W-1:0]    remaining_q;

    logic                push;
    logic                pop;
    logic                flush;
    logic                go_ok;
    logic                timeout;
    logic [LVL_W-1:0]    eff_level;
    logic [DATA_W-1:0]   head_now;

`ifdef ULPB_TX_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e              prev_state_q;
    logic [WD_W-1:0]     wd_q;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_active;

    // The count restarts on the first cycle of any newly entered state.
    always_comb begin
        wd_cnt    = (state_q != prev_state_q) ? '0 : wd_q;
        wd_active = (state_q == StReq) || (state_q == StAckLow) ||
                    (state_q == StAckFlush) || (state_q == StResp);
        timeout   = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            prev_state_q <= StIdle;
            wd_q         <= '0;
        end else begin
            prev_state_q <= state_q;
            wd_q         <= wd_active ? wd_cnt + WD_W'(1) : '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        push      = WR_EN && !WR_FULL && (state_q == StIdle);
        eff_level = FIFO_LEVEL + LVL_W'(push);
        go_ok     = (state_q == StIdle) && MSG_GO && (eff_level != '0);
        pop       = (state_q == StReq) && TX_ACK && !TX_FAIL && !timeout;
        flush     = (((state_q == StReq) || (state_q == StAckLow)) && TX_FAIL) || timeout;
        // An empty FIFO with a same-cycle write launches with the word being written.
        head_now  = (FIFO_LEVEL != '0) ? mem[rd_ptr_q] : WR_DATA;
    end

    always_ff @(posedge CLKIN) begin
        if (push) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            FIFO_LEVEL <= '0;
            WR_FULL    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (flush) begin
                rd_ptr_q   <= wr_ptr_q;
                FIFO_LEVEL <= '0;
                WR_FULL    <= 1'b0;
            end else if (push) begin
                FIFO_LEVEL <= FIFO_LEVEL + LVL_W'(1);
                WR_FULL    <= (FIFO_LEVEL == LVL_W'(DEPTH - 1));
            end else if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                FIFO_LEVEL <= FIFO_LEVEL - LVL_W'(1);
                WR_FULL    <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            MSG_BUSY    <= 1'b0;
            MSG_DONE    <= 1'b0;
            MSG_STATUS  <= 2'b00;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            PRIORITY    <= 1'b0;
            TX_RESP_ACK <= 1'b0;
        end else begin
            MSG_DONE <= 1'b0;
            if (timeout) begin
                TX_REQ      <= 1'b0;
                TX_PEND     <= 1'b0;
                remaining_q <= '0;
                MSG_STATUS  <= 2'b11;
                MSG_BUSY    <= 1'b0;
                MSG_DONE    <= 1'b1;
                state_q     <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (go_ok) begin
                            remaining_q <= eff_level;
                            TX_ADDR     <= MSG_ADDR;
                            PRIORITY    <= MSG_PRIORITY;
                            MSG_STATUS  <= 2'b00;
                            MSG_BUSY    <= 1'b1;
                            TX_REQ      <= 1'b1;
                            TX_DATA     <= head_now;
                            TX_PEND     <= (eff_level > LVL_W'(1));
                            state_q     <= StReq;
                        end
                    end
                    StReq: begin
                        if (TX_FAIL) begin
                            TX_REQ      <= 1'b0;
                            TX_PEND     <= 1'b0;
                            remaining_q <= '0;
                            if (TX_ACK) begin
                                state_q <= StAckFlush;
                            end else begin
                                TX_RESP_ACK <= 1'b1;
                                MSG_STATUS  <= 2'b10;
                                state_q     <= StRack;
                            end
                        end else if (TX_ACK) begin
                            TX_REQ      <= 1'b0;
                            remaining_q <= remaining_q - LVL_W'(1);
                            state_q     <= StAckLow;
                        end
                    end
                    StAckLow: begin
                        if (TX_FAIL) begin
                            TX_PEND     <= 1'b0;
                            remaining_q <= '0;
                            if (TX_ACK) begin
                                state_q <= StAckFlush;
                            end else begin
                                TX_RESP_ACK <= 1'b1;
                                MSG_STATUS  <= 2'b10;
                                state_q     <= StRack;
                            end
                        end else if (!TX_ACK) begin
                            if (remaining_q != '0) begin
                                // Head pointer already advanced when this state was entered.
                                TX_REQ  <= 1'b1;
                                TX_DATA <= mem[rd_ptr_q];
                                TX_PEND <= (remaining_q > LVL_W'(1));
                                state_q <= StReq;
                            end else begin
                                state_q <= StResp;
                            end
                        end
                    end
                    StAckFlush: begin
                        if (!TX_ACK) begin
                            TX_RESP_ACK <= 1'b1;
                            MSG_STATUS  <= 2'b10;
                            state_q     <= StRack;
                        end
                    end
                    StResp: begin
                        if (TX_FAIL) begin
                            TX_RESP_ACK <= 1'b1;
                            MSG_STATUS  <= 2'b10;
                            state_q     <= StRack;
                        end else if (TX_SUCC) begin
                            TX_RESP_ACK <= 1'b1;
                            MSG_STATUS  <= 2'b01;
                            state_q     <= StRack;
                        end
                    end
                    StRack: begin
                        if (!TX_SUCC && !TX_FAIL) begin
                            TX_RESP_ACK <= 1'b0;
                            MSG_BUSY    <= 1'b0;
                            MSG_DONE    <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ulpb_lc_tx_sequencer.sv
// Self-checking bench for ulpb_lc_tx_sequencer: fixed vectors, directed handshakes and randomized
// messages checked against a queue-based model of the FIFO and message rules.
module tb_ulpb_lc_tx_sequencer;

    localparam int DEPTH = 4;

    logic        CLKIN = 1'b0;
    logic        RESETn;
    logic        WR_EN = 1'b0;
    logic [31:0] WR_DATA = '0;
    logic        WR_FULL;
    logic [2:0]  FIFO_LEVEL;
    logic [7:0]  MSG_ADDR = '0;
    logic        MSG_PRIORITY = 1'b0;
    logic        MSG_GO = 1'b0;
    logic        MSG_BUSY;
    logic        MSG_DONE;
    logic [1:0]  MSG_STATUS;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_REQ;
    logic        TX_PEND;
    logic        PRIORITY;
    logic        TX_ACK = 1'b0;
    logic        TX_SUCC = 1'b0;
    logic        TX_FAIL = 1'b0;
    logic        TX_RESP_ACK;

    ulpb_lc_tx_sequencer #(
        .DEPTH(DEPTH),
        .ADDR_W(8),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLKIN(CLKIN), .RESETn(RESETn),
        .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL), .FIFO_LEVEL(FIFO_LEVEL),
        .MSG_ADDR(MSG_ADDR), .MSG_PRIORITY(MSG_PRIORITY), .MSG_GO(MSG_GO),
        .MSG_BUSY(MSG_BUSY), .MSG_DONE(MSG_DONE), .MSG_STATUS(MSG_STATUS),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
        .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK)
    );

    always #5 CLKIN = ~CLKIN;

    int checks = 0;
    int errors = 0;

    // Model: words accepted into the FIFO, and the words of the message in flight.
    logic [31:0] model_q[$];
    logic [31:0] msg_q[$];
    logic [7:0]  exp_addr;
    logic        exp_pri;

    typedef struct {
        logic        wr_en;
        logic [31:0] data;
        logic [2:0]  exp_level;
        logic        exp_full;
    } wr_vec_t;

    wr_vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic wr(input logic en, input logic [31:0] d);
        WR_EN = en;
        WR_DATA = d;
        step();
        WR_EN = 1'b0;
        if (en && model_q.size() < DEPTH) model_q.push_back(d);
        chk("wr_level", FIFO_LEVEL, model_q.size());
        chk("wr_full", WR_FULL, model_q.size() == DEPTH);
    endtask

    task automatic go(input logic [7:0] a, input logic p, input logic w, input logic [31:0] d,
                      output bit launched);
        WR_EN = w;
        WR_DATA = d;
        MSG_ADDR = a;
        MSG_PRIORITY = p;
        MSG_GO = 1'b1;
        step();
        WR_EN = 1'b0;
        MSG_GO = 1'b0;
        MSG_ADDR = ~a;
        MSG_PRIORITY = ~p;
        if (w && model_q.size() < DEPTH) model_q.push_back(d);
        launched = (model_q.size() != 0);
        if (launched) begin
            msg_q = model_q;
            model_q.delete();
            exp_addr = a;
            exp_pri = p;
            chk("go_req", TX_REQ, 1);
            chk("go_busy", MSG_BUSY, 1);
            chk("go_status_clr", MSG_STATUS, 0);
        end else begin
            chk("empty_go_req", TX_REQ, 0);
            chk("empty_go_busy", MSG_BUSY, 0);
        end
    endtask

    task automatic finish_msg(input logic [1:0] st);
        chk("done_pulse", MSG_DONE, 1);
        chk("done_busy", MSG_BUSY, 0);
        chk("done_resp_ack", TX_RESP_ACK, 0);
        chk("done_status", MSG_STATUS, st);
        chk("done_level", FIFO_LEVEL, 0);
        chk("done_req", TX_REQ, 0);
        step();
        chk("done_single", MSG_DONE, 0);
        chk("status_hold", MSG_STATUS, st);
    endtask

    // outcome: 1 succ, 2 fail, 3 both (fail wins). fail_idx >= 0 fails early on that word.
    task automatic serve(input int fail_idx, input bit fail_ack, input int ack_dly,
                         input int outcome);
        int len;
        logic [1:0] st;
        len = msg_q.size();
        for (int i = 0; i < len; i++) begin
            chk("tx_req", TX_REQ, 1);
            chk("tx_data", TX_DATA, msg_q[i]);
            chk("tx_pend", TX_PEND, i < len - 1);
            chk("tx_addr", TX_ADDR, exp_addr);
            chk("priority", PRIORITY, exp_pri);
            if (i == fail_idx) begin
                TX_FAIL = 1'b1;
                TX_ACK = fail_ack;
                step();
                chk("fail_req_drop", TX_REQ, 0);
                chk("fail_flush", FIFO_LEVEL, 0);
                if (fail_ack) begin
                    chk("flush_wait_ack", TX_RESP_ACK, 0);
                    TX_ACK = 1'b0;
                    step();
                end
                chk("fail_resp_ack", TX_RESP_ACK, 1);
                chk("fail_status", MSG_STATUS, 2);
                chk("fail_busy", MSG_BUSY, 1);
                TX_FAIL = 1'b0;
                step();
                finish_msg(2'b10);
                return;
            end
            for (int d = 0; d < ack_dly; d++) begin
                step();
                chk("req_hold", TX_REQ, 1);
                chk("data_hold", TX_DATA, msg_q[i]);
            end
            TX_ACK = 1'b1;
            step();
            chk("req_fall", TX_REQ, 0);
            chk("pop_level", FIFO_LEVEL, len - i - 1);
            TX_ACK = 1'b0;
            step();
        end
        chk("resp_req_low", TX_REQ, 0);
        chk("resp_no_ack", TX_RESP_ACK, 0);
        TX_SUCC = outcome[0];
        TX_FAIL = outcome[1];
        st = (outcome == 1) ? 2'b01 : 2'b10;
        step();
        chk("rack_resp_ack", TX_RESP_ACK, 1);
        chk("rack_status", MSG_STATUS, st);
        TX_SUCC = 1'b0;
        TX_FAIL = 1'b0;
        step();
        finish_msg(st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit launched;
        int n;
        int len;
        int fidx;

        tbl[0] = '{1'b1, 32'h1111_0001, 3'd1, 1'b0};
        tbl[1] = '{1'b1, 32'h2222_0002, 3'd2, 1'b0};
        tbl[2] = '{1'b1, 32'h3333_0003, 3'd3, 1'b0};
        tbl[3] = '{1'b1, 32'h4444_0004, 3'd4, 1'b1};
        tbl[4] = '{1'b1, 32'h5555_0005, 3'd4, 1'b1};
        tbl[5] = '{1'b0, 32'h6666_0006, 3'd4, 1'b1};

        RESETn = 1'b0;
        #12;
        chk("rst_outputs", {TX_REQ, TX_PEND, TX_RESP_ACK, MSG_BUSY, MSG_DONE, WR_FULL}, 0);
        chk("rst_level", FIFO_LEVEL, 0);
        chk("rst_status", MSG_STATUS, 0);
        @(negedge CLKIN);
        RESETn = 1'b1;

        // Single word, node ACK after 3 cycles, success.
        wr(1'b1, 32'hA5A5_0001);
        go(8'h12, 1'b0, 1'b0, 32'h0, launched);
        serve(-1, 1'b0, 3, 1);

        // Fill to full; the fifth write is dropped.
        for (int i = 0; i < 6; i++) begin
            wr(tbl[i].wr_en, tbl[i].data);
            chk("tbl_level", FIFO_LEVEL, tbl[i].exp_level);
            chk("tbl_full", WR_FULL, tbl[i].exp_full);
        end
        go(8'h34, 1'b1, 1'b1, 32'hDEAD_BEEF, launched);
        chk("full_len", msg_q.size(), 4);
        serve(-1, 1'b0, 1, 1);

        // Three words, fail during the second REQ.
        for (int i = 0; i < 3; i++) wr(1'b1, 32'hC0DE_0000 + i);
        go(8'h56, 1'b0, 1'b0, 32'h0, launched);
        serve(1, 1'b0, 0, 1);

        // Same-cycle write and GO with level 1, then GO on an empty FIFO.
        wr(1'b1, 32'h0000_00AA);
        go(8'h78, 1'b1, 1'b1, 32'h0000_00BB, launched);
        chk("samecyc_len", msg_q.size(), 2);
        serve(-1, 1'b0, 2, 1);
        go(8'h9A, 1'b0, 1'b0, 32'h0, launched);
        step();
        chk("empty_go_idle_req", TX_REQ, 0);
        chk("empty_go_idle_busy", MSG_BUSY, 0);

        // Fail while TX_ACK is high: wait for ACK low before the response handshake.
        wr(1'b1, 32'hF00D_0001);
        wr(1'b1, 32'hF00D_0002);
        go(8'hBC, 1'b0, 1'b0, 32'h0, launched);
        serve(0, 1'b1, 1, 1);

        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) wr($urandom_range(0, 3) != 0, $urandom());
            go(8'($urandom()), 1'($urandom()), 1'($urandom()), $urandom(), launched);
            if (launched) begin
                len = msg_q.size();
                fidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                serve(fidx, 1'($urandom()), $urandom_range(0, 3), $urandom_range(1, 3));
            end else begin
                step();
            end
        end

        // Asynchronous reset while in ACKLOW with TX_ACK high.
        wr(1'b1, 32'h7777_0001);
        wr(1'b1, 32'h7777_0002);
        go(8'hDE, 1'b1, 1'b0, 32'h0, launched);
        TX_ACK = 1'b1;
        step();
        chk("pre_rst_level", FIFO_LEVEL, 1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("arst_ctrl", {TX_REQ, TX_PEND, TX_RESP_ACK, MSG_BUSY, MSG_DONE, WR_FULL, PRIORITY}, 0);
        chk("arst_addr_data", {TX_ADDR, TX_DATA}, 0);
        chk("arst_level", FIFO_LEVEL, 0);
        chk("arst_status", MSG_STATUS, 0);
        TX_ACK = 1'b0;
        model_q.delete();
        msg_q.delete();
        @(negedge CLKIN);
        RESETn = 1'b1;
        step();
        chk("post_rst_level", FIFO_LEVEL, 0);

`ifdef ULPB_TX_SEQ_TIMEOUT_EN
        wr(1'b1, 32'h1234_5678);
        go(8'h11, 1'b0, 1'b0, 32'h0, launched);
        for (int c = 0; c < 15; c++) begin
            step();
            chk("to_req_high", TX_REQ, 1);
        end
        step();
        chk("to_req_drop", TX_REQ, 0);
        chk("to_status", MSG_STATUS, 3);
        chk("to_done", MSG_DONE, 1);
        chk("to_busy", MSG_BUSY, 0);
        chk("to_level", FIFO_LEVEL, 0);
        chk("to_no_resp_ack", TX_RESP_ACK, 0);
        step();
        chk("to_done_single", MSG_DONE, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
